// File: rtl/gen_origin_axis_sched.sv
// ---------------------------------------------------------------------------
// gen_origin_axis_sched
//
// Round-robin scheduler sharing one origin-stream generator among NUM
// requesters. A granted request is latched onto the generator command port,
// the generator is launched, its output stream is watched for the final beat,
// and a one-cycle done pulse is returned to the requester that owned the frame.
//
// Parameters
//   NUM  number of requesters (2..16)
//   GAP  idle cycles inserted after each completed frame (0..255)
//
// Ports
//   clock, rst_n        clock and asynchronous active-low reset
//   req_valid/ready     per-requester request, one-hot one-cycle accept pulse
//   req_start/length    per-requester command, slice i = [32*i +: 32]
//   done                one-hot one-cycle frame-complete pulse
//   gen_enable/ready    generator launch handshake
//   gen_start/length    command latched at grant, held until the next grant
//   mon_*               taps of the generator's AXI-Stream output
//   busy                high whenever the scheduler is not idle
//   owner               index of the current / most recent grant
//   err                 sticky watchdog flag
//
// Optional build macro
//   GEN_ORIGIN_SCHED_WDOG_EN  adds a 16-bit watchdog on frames that never end;
//                             without it err is tied low and a frame waits
//                             for its last beat forever.
// ---------------------------------------------------------------------------
module gen_origin_axis_sched #(
  parameter int NUM = 4,
  parameter int GAP = 0
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [NUM-1:0]          req_valid,
  input  logic [NUM*32-1:0]       req_start,
  input  logic [NUM*32-1:0]       req_length,
  output logic [NUM-1:0]          req_ready,
  output logic [NUM-1:0]          done,
  output logic                    gen_enable,
  input  logic                    gen_ready,
  output logic [31:0]             gen_start,
  output logic [31:0]             gen_length,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tlast,
  input  logic                    mon_aclken,
  output logic                    busy,
  output logic [$clog2(NUM)-1:0]  owner,
  output logic                    err
);

  localparam int IW = $clog2(NUM);
  localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic [NUM-1:0] ONE_HOT0 = {{(NUM-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_LAST,
    S_GAP,
    S_ZERO
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [31:0]     r_start;
  logic [31:0]     r_length;
  logic [NUM-1:0]  r_req_ready;
  logic [NUM-1:0]  r_done;
  logic            r_gen_enable;
  logic [7:0]      r_gap_cnt;

  logic            w_found;
  logic [IW-1:0]   w_grant;
  logic [IW-1:0]   w_cand;
  logic [31:0]     w_sel_start;
  logic [31:0]     w_sel_len;
  logic            w_last_beat;
  logic            w_wdog_fire;

  // Search for the first pending request strictly after the last grant,
  // wrapping around, so every requester gets a turn within NUM frames.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int off = 1; off <= NUM; off++) begin
      w_cand = IW'((int'(r_ptr) + off) % NUM);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // Command slice of the requester that would win this cycle.
  always_comb begin
    w_sel_start = req_start[32*int'(w_grant) +: 32];
    w_sel_len   = req_length[32*int'(w_grant) +: 32];
  end

  // A frame ends only on a real handshake of the tlast beat; beats with
  // aclken low do not count.
  assign w_last_beat = mon_tvalid && mon_tready && mon_tlast && mon_aclken;

`ifdef GEN_ORIGIN_SCHED_WDOG_EN
  logic [15:0] r_wdog;
  logic        r_err;
  logic        w_xfer;

  // Any accepted beat counts as progress and restarts the watchdog.
  assign w_xfer      = mon_tvalid && mon_tready;
  assign w_wdog_fire = (r_state == S_WAIT_LAST) && !w_last_beat && !w_xfer &&
                       (r_wdog == 16'hFFFF);

  // Watchdog counts stalled WAIT_LAST cycles; it sits at zero in every other
  // state so entering WAIT_LAST always starts from a clean count.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state != S_WAIT_LAST) || w_xfer) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + 16'd1;
      end
      if (w_wdog_fire) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_wdog_fire = 1'b0;
  assign err         = 1'b0;
`endif

  // Main scheduler FSM. req_ready and done are single-cycle pulses, so they
  // are cleared every cycle and only set on the edge that produces them.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= IW'(NUM - 1);
      r_owner      <= '0;
      r_start      <= '0;
      r_length     <= '0;
      r_req_ready  <= '0;
      r_done       <= '0;
      r_gen_enable <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      r_req_ready <= '0;
      r_done      <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ptr       <= w_grant;
            r_owner     <= w_grant;
            r_start     <= w_sel_start;
            r_length    <= w_sel_len;
            r_req_ready <= ONE_HOT0 << w_grant;
            // Empty frames never touch the generator.
            if (w_sel_len == 32'd0) begin
              r_state <= S_ZERO;
            end else begin
              r_gen_enable <= 1'b1;
              r_state      <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          if (r_gen_enable && gen_ready) begin
            r_gen_enable <= 1'b0;
            r_state      <= S_WAIT_LAST;
          end
        end
        S_WAIT_LAST: begin
          if (w_last_beat || w_wdog_fire) begin
            r_done <= ONE_HOT0 << r_owner;
            if (GAP > 0) begin
              r_gap_cnt <= GAP_LOAD;
              r_state   <= S_GAP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 8'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        S_ZERO: begin
          r_done  <= ONE_HOT0 << r_owner;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign done       = r_done;
  assign gen_enable = r_gen_enable;
  assign gen_start  = r_start;
  assign gen_length = r_length;
  assign owner      = r_owner;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_gen_origin_axis_sched.sv
// ---------------------------------------------------------------------------
// tb_gen_origin_axis_sched
//
// Two scheduler instances share the clock: index 0 built with GAP=0 and
// index 1 built with GAP=3. The bench plays the generator and the stream
// monitor, keeps its own round-robin view of which request should win next,
// and checks grant order, latched commands, launch handshake, done timing,
// inter-frame gap, zero-length frames, asynchronous reset and the watchdog.
// ---------------------------------------------------------------------------
module tb_gen_origin_axis_sched;

  localparam int NUM   = 4;
  localparam int GAP_A = 0;
  localparam int GAP_B = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]                rstN;
  logic [1:0][NUM-1:0]       reqValid;
  logic [1:0][NUM*32-1:0]    reqStart;
  logic [1:0][NUM*32-1:0]    reqLength;
  logic [1:0][NUM-1:0]       reqReady;
  logic [1:0][NUM-1:0]       done;
  logic [1:0]                genEnable;
  logic [1:0]                genReady;
  logic [1:0][31:0]          genStart;
  logic [1:0][31:0]          genLength;
  logic [1:0]                monTvalid;
  logic [1:0]                monTready;
  logic [1:0]                monTlast;
  logic [1:0]                monAclken;
  logic [1:0]                busy;
  logic [1:0][1:0]           owner;
  logic [1:0]                err;

  gen_origin_axis_sched #(.NUM(NUM), .GAP(GAP_A)) dutA (
    .clock(clock), .rst_n(rstN[0]),
    .req_valid(reqValid[0]), .req_start(reqStart[0]), .req_length(reqLength[0]),
    .req_ready(reqReady[0]), .done(done[0]),
    .gen_enable(genEnable[0]), .gen_ready(genReady[0]),
    .gen_start(genStart[0]), .gen_length(genLength[0]),
    .mon_tvalid(monTvalid[0]), .mon_tready(monTready[0]),
    .mon_tlast(monTlast[0]), .mon_aclken(monAclken[0]),
    .busy(busy[0]), .owner(owner[0]), .err(err[0])
  );

  gen_origin_axis_sched #(.NUM(NUM), .GAP(GAP_B)) dutB (
    .clock(clock), .rst_n(rstN[1]),
    .req_valid(reqValid[1]), .req_start(reqStart[1]), .req_length(reqLength[1]),
    .req_ready(reqReady[1]), .done(done[1]),
    .gen_enable(genEnable[1]), .gen_ready(genReady[1]),
    .gen_start(genStart[1]), .gen_length(genLength[1]),
    .mon_tvalid(monTvalid[1]), .mon_tready(monTready[1]),
    .mon_tlast(monTlast[1]), .mon_aclken(monAclken[1]),
    .busy(busy[1]), .owner(owner[1]), .err(err[1])
  );

  // Reference state: last granted index per instance and the command each
  // requester is currently holding.
  int          gapOf [2];
  int          rrPtr [2];
  logic [31:0] mStart [2][NUM];
  logic [31:0] mLen   [2][NUM];
  int          testCount = 0;
  int          failCount = 0;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Raise a request and remember what it carries.
  task automatic applyStimulus(input int d, input int idx, input logic [31:0] start,
                               input logic [31:0] len);
    mStart[d][idx]               = start;
    mLen[d][idx]                 = len;
    reqStart[d][32*idx +: 32]    = start;
    reqLength[d][32*idx +: 32]   = len;
    reqValid[d][idx]             = 1'b1;
  endtask

  // Next winner: first held request after the previous grant, cyclically.
  function automatic int rrNext(input int d);
    for (int off = 1; off <= NUM; off++) begin
      int j;
      j = (rrPtr[d] + off) % NUM;
      if (reqValid[d][j]) return j;
    end
    return -1;
  endfunction

  task automatic clearMonitor(input int d);
    monTvalid[d] = 1'b0;
    monTready[d] = 1'b0;
    monTlast[d]  = 1'b0;
    monAclken[d] = 1'b0;
  endtask

  task automatic checkReset(input int d);
    checkOutput("rst_busy",       busy[d],      0);
    checkOutput("rst_req_ready",  reqReady[d],  0);
    checkOutput("rst_done",       done[d],      0);
    checkOutput("rst_gen_enable", genEnable[d], 0);
    checkOutput("rst_gen_start",  genStart[d],  0);
    checkOutput("rst_gen_length", genLength[d], 0);
    checkOutput("rst_owner",      owner[d],     0);
    checkOutput("rst_err",        err[d],       0);
  endtask

  // Wait out any gap and confirm the scheduler settles idle.
  task automatic idleCheck(input int d);
    tick();
    checkOutput("done_one_cycle", done[d], 0);
    repeat (gapOf[d]) tick();
    checkOutput("idle_busy",      busy[d],      0);
    checkOutput("idle_enable",    genEnable[d], 0);
    checkOutput("idle_req_ready", reqReady[d],  0);
  endtask

  // One complete frame: grant, launch handshake, stream beats, done.
  // expWait is the number of ticks until req_ready must appear.
  task automatic runFrame(input int d, input int expWait, input bit stallMode,
                          input bit rearm, output int waitAfter);
    int g, cnt, r, sent, stallLeft;
    bit acTried, lastNow, tv, tr, ac, tl;
    logic [31:0] s, l;
    waitAfter = 1;
    g = rrNext(d);
    if (g < 0) begin
      failCount++;
      $display("[TB] FAIL no_pending observed=none expected=request");
      return;
    end
    s = mStart[d][g];
    l = mLen[d][g];
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (reqReady[d] == '0 && cnt < 300);
    checkOutput("grant_latency", cnt, expWait);
    checkOutput("req_ready",     reqReady[d],  1 << g);
    checkOutput("owner",         owner[d],     g);
    checkOutput("gen_start",     genStart[d],  s);
    checkOutput("gen_length",    genLength[d], l);
    checkOutput("busy_grant",    busy[d],      1);
    reqValid[d][g] = 1'b0;
    rrPtr[d] = g;
    if (rearm) applyStimulus(d, g, $urandom, $urandom_range(1, 6));

    if (l == 0) begin
      checkOutput("zero_no_enable", genEnable[d], 0);
      tick();
      checkOutput("zero_done",       done[d],      1 << g);
      checkOutput("zero_no_enable2", genEnable[d], 0);
      checkOutput("zero_idle",       busy[d],      0);
      waitAfter = 1;
      return;
    end

    checkOutput("enable_at_grant", genEnable[d], 1);
    r = stallMode ? 2 : int'($urandom_range(0, 3));
    genReady[d] = 1'b0;
    repeat (r) begin
      // A stray tlast beat while launching must be ignored.
      monTvalid[d] = 1'b1;
      monTready[d] = 1'b1;
      monTlast[d]  = 1'b1;
      monAclken[d] = 1'b1;
      tick();
      checkOutput("enable_held",       genEnable[d], 1);
      checkOutput("no_done_in_launch", done[d],      0);
    end
    clearMonitor(d);
    genReady[d] = 1'b1;
    tick();
    checkOutput("enable_drop", genEnable[d], 0);
    genReady[d] = 1'b0;

    sent = 0; cnt = 0; stallLeft = 5; acTried = 0; lastNow = 0;
    while (!lastNow && cnt < 400) begin
      if (stallMode && sent == 2 && stallLeft > 0) begin
        tv = 1; tr = 0; ac = 1;
        stallLeft--;
      end else if (stallMode && sent == int'(l) - 1 && !acTried) begin
        tv = 1; tr = 1; ac = 0;
        acTried = 1;
      end else begin
        tv = ($urandom_range(0, 3) != 0);
        tr = ($urandom_range(0, 3) != 0);
        ac = ($urandom_range(0, 7) != 0);
      end
      tl = tv ? (sent == int'(l) - 1) : bit'($urandom_range(0, 1));
      lastNow = tv && tr && ac && tl;
      if (tv && tr && ac) sent++;
      monTvalid[d] = tv;
      monTready[d] = tr;
      monAclken[d] = ac;
      monTlast[d]  = tl;
      tick();
      cnt++;
      if (!lastNow) checkOutput("no_early_done", done[d], 0);
    end
    clearMonitor(d);
    checkOutput("frame_done",       done[d],      1 << g);
    checkOutput("busy_after_done",  busy[d],      (gapOf[d] > 0) ? 1 : 0);
    checkOutput("gen_start_stable", genStart[d],  s);
    checkOutput("gen_len_stable",   genLength[d], l);
    waitAfter = gapOf[d] + 1;
  endtask

  // Add random new requests on idle requesters; always leave one pending.
  task automatic armRandom(input int d);
    for (int i = 0; i < NUM; i++) begin
      if (!reqValid[d][i] && $urandom_range(0, 2) == 0)
        applyStimulus(d, i, $urandom,
                      ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 6)));
    end
    if (reqValid[d] == '0)
      applyStimulus(d, int'($urandom_range(0, NUM - 1)), $urandom,
                    ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 6)));
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    int w;
    gapOf[0] = GAP_A;
    gapOf[1] = GAP_B;
    rstN      = '0;
    reqValid  = '0;
    reqStart  = '0;
    reqLength = '0;
    genReady  = '0;
    monTvalid = '0;
    monTready = '0;
    monTlast  = '0;
    monAclken = '0;
    for (int d = 0; d < 2; d++) rrPtr[d] = NUM - 1;

    tick();
    checkReset(0);
    checkReset(1);
    rstN = '1;
    tick();

    // All requesters held valid, no gap: strict rotation starting at 0.
    for (int i = 0; i < NUM; i++) applyStimulus(0, i, $urandom, $urandom_range(1, 6));
    w = 1;
    for (int k = 0; k < 5; k++) begin
      runFrame(0, w, 0, 1, w);
      checkOutput("rr_order", owner[0], order[k]);
    end
    reqValid[0] = '0;
    idleCheck(0);

    // Single request with a known command.
    applyStimulus(0, 0, 32'h10, 32'd4);
    runFrame(0, 1, 0, 0, w);
    idleCheck(0);

    // Stream backpressure and an aclken-low tlast beat.
    applyStimulus(0, 1, $urandom, 32'd4);
    runFrame(0, 1, 1, 0, w);
    idleCheck(0);

    // Zero-length request bypasses the generator.
    applyStimulus(0, 2, $urandom, 32'd0);
    runFrame(0, 1, 0, 0, w);
    idleCheck(0);

    // Randomised traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      w = 1;
      for (int f = 0; f < 20; f++) begin
        armRandom(d);
        runFrame(d, w, 0, 0, w);
      end
      while (reqValid[d] != '0) runFrame(d, w, 0, 0, w);
      idleCheck(d);
    end

    // GAP=3: delayed gen_ready, then the next grant lands gap+2 after tlast.
    applyStimulus(1, 1, $urandom, 32'd4);
    runFrame(1, 1, 1, 0, w);
    applyStimulus(1, 3, $urandom, 32'd3);
    runFrame(1, w, 0, 0, w);
    idleCheck(1);

    // Reset in WAIT_LAST clears everything at once; restart serves 0 first.
    applyStimulus(1, 2, $urandom, 32'd5);
    tick();
    checkOutput("pre_rst_grant", reqReady[1], 1 << 2);
    reqValid[1][2] = 1'b0;
    genReady[1] = 1'b1;
    tick();
    genReady[1] = 1'b0;
    monTvalid[1] = 1'b1;
    monTready[1] = 1'b1;
    monAclken[1] = 1'b1;
    tick();
    clearMonitor(1);
    checkOutput("pre_rst_busy", busy[1], 1);
    #2;
    rstN[1] = 1'b0;
    #1;
    checkReset(1);
    for (int i = 0; i < NUM; i++) applyStimulus(1, i, $urandom, $urandom_range(1, 4));
    tick();
    tick();
    rstN[1] = 1'b1;
    rrPtr[1] = NUM - 1;
    runFrame(1, 1, 0, 0, w);
    checkOutput("restart_owner", owner[1], 0);
    while (reqValid[1] != '0) runFrame(1, w, 0, 0, w);
    idleCheck(1);

    // Frame that never delivers tlast.
    applyStimulus(0, 3, $urandom, 32'd8);
    tick();
    checkOutput("wdog_grant", reqReady[0], 1 << 3);
    reqValid[0][3] = 1'b0;
    genReady[0] = 1'b1;
    tick();
    genReady[0] = 1'b0;
`ifdef GEN_ORIGIN_SCHED_WDOG_EN
    begin
      int cnt;
      cnt = 0;
      while (done[0] == '0 && cnt < 70000) begin
        tick();
        cnt++;
      end
      checkOutput("wdog_done", done[0], 1 << 3);
      checkOutput("wdog_err",  err[0],  1);
      checkOutput("wdog_idle", busy[0], 0);
      tick();
      checkOutput("wdog_err_sticky", err[0], 1);
    end
`else
    repeat (300) tick();
    checkOutput("no_wdog_err",  err[0],  0);
    checkOutput("no_wdog_busy", busy[0], 1);
    checkOutput("no_wdog_done", done[0], 0);
    #2;
    rstN[0] = 1'b0;
    #1;
    checkReset(0);
    tick();
    rstN[0] = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
